// File: rtl/fwd_pkg.sv
// Shared types and select-code helpers for the operand-forwarding / load-use hazard unit.
// Select code layout: 0 = register file, s+1 = forwarding stage s, NUM_STAGES+1 = immediate.
package fwd_pkg;

    typedef enum logic {
        FWD_RUN   = 1'b0,
        FWD_STALL = 1'b1
    } fwd_state_e;

    localparam int SEL_RF = 0;

    function automatic int fwd_sel_w(input int num_stages);
        return $clog2(num_stages + 2);
    endfunction

    function automatic int sel_imm(input int num_stages);
        return num_stages + 1;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority compare of one source register against every downstream destination (youngest wins).
// Latency: combinational. Backpressure: none; caller decides what to do with the load hit.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = fwd_sel_w(NUM_STAGES)
) (
    input  logic                         id_valid,
    input  logic                         uses_rs,
    input  logic [REG_AW-1:0]            rs,
    input  logic [NUM_STAGES*REG_AW-1:0] st_rd,
    input  logic [NUM_STAGES-1:0]        st_wr,
    input  logic                         st_load0,
    output logic [SEL_W-1:0]             code,
    output logic                         load_hit
);

    logic [NUM_STAGES-1:0] hit;

    always_comb begin
        hit  = '0;
        code = SEL_W'(SEL_RF);
        for (int s = 0; s < NUM_STAGES; s++) begin
            hit[s] = id_valid & uses_rs & (rs != '0) & st_wr[s]
                   & (rs == st_rd[s*REG_AW +: REG_AW]);
        end
        // Walk oldest to youngest so the youngest producer overwrites last.
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            if (hit[s]) code = SEL_W'(s + 1);
        end
        load_hit = hit[0] & st_load0;
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Registered operand-forwarding selects plus one-cycle load-use stall/bubble between ID and EX.
// Latency: 1 cycle for all outputs. Backpressure: stall holds PC/IF-ID; optional FWD_STALL_CNT_EN counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = fwd_sel_w(NUM_STAGES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]           id_uses_rs,
    input  logic                         id_alusrc,
    input  logic [NUM_STAGES*REG_AW-1:0] st_rd,
    input  logic [NUM_STAGES-1:0]        st_wr,
    input  logic [NUM_STAGES-1:0]        st_load,
    output logic [NUM_SRC*SEL_W-1:0]     src_sel,
    output logic [SEL_W-1:0]             store_sel,
    output logic                         stall,
    output logic                         bubble
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    logic [NUM_SRC*SEL_W-1:0] codes;
    logic [NUM_SRC-1:0]       load_hit;
    logic                     unused_st_load;

    // Only the youngest stage can hold a load whose data is still in flight.
    assign unused_st_load = ^st_load;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_src_match #(
            .NUM_STAGES (NUM_STAGES),
            .REG_AW     (REG_AW),
            .SEL_W      (SEL_W)
        ) u_match (
            .id_valid (id_valid),
            .uses_rs  (id_uses_rs[k]),
            .rs       (id_rs[k*REG_AW +: REG_AW]),
            .st_rd    (st_rd),
            .st_wr    (st_wr),
            .st_load0 (st_load[0]),
            .code     (codes[k*SEL_W +: SEL_W]),
            .load_hit (load_hit[k])
        );
    end

    fwd_state_e               state_q, state_d;
    logic [NUM_SRC*SEL_W-1:0] src_sel_q, src_sel_d;
    logic [SEL_W-1:0]         store_sel_q, store_sel_d;
    logic                     stall_q, stall_d;
    logic                     bubble_q, bubble_d;
    logic                     hazard;

    always_comb begin
        // In STALL the load has advanced to stage 1 and stage 0 carries the bubble.
        hazard      = (state_q == FWD_RUN) & (|load_hit);
        src_sel_d   = '0;
        store_sel_d = '0;
        stall_d     = 1'b0;
        bubble_d    = 1'b0;
        state_d     = FWD_RUN;
        if (!flush) begin
            src_sel_d = codes;
            if (id_alusrc) src_sel_d[SEL_W +: SEL_W] = SEL_W'(sel_imm(NUM_STAGES));
            store_sel_d = codes[SEL_W +: SEL_W];
            stall_d     = hazard;
            bubble_d    = hazard;
            state_d     = hazard ? FWD_STALL : FWD_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FWD_RUN;
            src_sel_q   <= '0;
            store_sel_q <= '0;
            stall_q     <= 1'b0;
            bubble_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_sel_q   <= src_sel_d;
            store_sel_q <= store_sel_d;
            stall_q     <= stall_d;
            bubble_q    <= bubble_d;
        end
    end

    assign src_sel   = src_sel_q;
    assign store_sel = store_sel_q;
    assign stall     = stall_q;
    assign bubble    = bubble_q;

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_q && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit at default parameters (2 sources, 2 stages, 2-bit codes).
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_uses_rs;
    logic        id_alusrc;
    logic [9:0]  st_rd;
    logic [1:0]  st_wr;
    logic [1:0]  st_load;
    logic [3:0]  src_sel;
    logic [1:0]  store_sel;
    logic        stall;
    logic        bubble;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_uses_rs (id_uses_rs),
        .id_alusrc  (id_alusrc),
        .st_rd      (st_rd),
        .st_wr      (st_wr),
        .st_load    (st_load),
        .src_sel    (src_sel),
        .store_sel  (store_sel),
        .stall      (stall),
        .bubble     (bubble)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // Source 0 address, source 1 address, uses, alusrc, stage-0 rd, stage-1 rd, wr, load.
    task automatic set_in(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] uses,
                          input logic alusrc, input logic [4:0] rd0, input logic [4:0] rd1,
                          input logic [1:0] wr, input logic [1:0] ld);
        id_valid   = 1'b1;
        id_rs      = {rs1, rs0};
        id_uses_rs = uses;
        id_alusrc  = alusrc;
        st_rd      = {rd1, rd0};
        st_wr      = wr;
        st_load    = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        set_in(5'd5, 5'd5, 2'b11, 1'b1, 5'd5, 5'd5, 2'b11, 2'b01);
        step(); step();
        checks++; if (src_sel !== 4'b0000) begin errors++; $display("FAIL reset_src_sel got %b want 0000", src_sel); end
        checks++; if (store_sel !== 2'd0) begin errors++; $display("FAIL reset_store_sel got %0d want 0", store_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", bubble); end
`ifdef FWD_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
`endif
        set_in(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_forward_basic();
        set_in(5'd5, 5'd3, 2'b11, 1'b0, 5'd5, 5'd8, 2'b01, 2'b00);
        step();
        checks++; if (src_sel !== 4'b0001) begin errors++; $display("FAIL fwd_stage0 got %b want 0001", src_sel); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_stage0_stall got %b want 0", stall); end
        set_in(5'd6, 5'd3, 2'b11, 1'b0, 5'd2, 5'd6, 2'b11, 2'b00);
        step();
        checks++; if (src_sel !== 4'b0010) begin errors++; $display("FAIL fwd_stage1 got %b want 0010", src_sel); end
    endtask

    task automatic test_youngest_and_imm();
        set_in(5'd3, 5'd7, 2'b11, 1'b0, 5'd7, 5'd7, 2'b11, 2'b00);
        step();
        checks++; if (src_sel !== 4'b0100) begin errors++; $display("FAIL youngest got %b want 0100", src_sel); end
        checks++; if (store_sel !== 2'd1) begin errors++; $display("FAIL youngest_store got %0d want 1", store_sel); end
        id_alusrc = 1'b1;
        step();
        checks++; if (src_sel !== 4'b1100) begin errors++; $display("FAIL imm_sel got %b want 1100", src_sel); end
        checks++; if (store_sel !== 2'd1) begin errors++; $display("FAIL imm_store got %0d want 1", store_sel); end
    endtask

    task automatic test_no_forward();
        set_in(5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 5'd0, 2'b11, 2'b00);
        step();
        checks++; if (src_sel !== 4'b0000) begin errors++; $display("FAIL x0 got %b want 0000", src_sel); end
        set_in(5'd4, 5'd0, 2'b10, 1'b0, 5'd4, 5'd4, 2'b11, 2'b00);
        step();
        checks++; if (src_sel !== 4'b0000) begin errors++; $display("FAIL unused_rs got %b want 0000", src_sel); end
        set_in(5'd4, 5'd4, 2'b11, 1'b0, 5'd4, 5'd4, 2'b11, 2'b00);
        id_valid = 1'b0;
        step();
        checks++; if (src_sel !== 4'b0000) begin errors++; $display("FAIL invalid_id got %b want 0000", src_sel); end
    endtask

    task automatic test_load_use();
        set_in(5'd9, 5'd1, 2'b11, 1'b0, 5'd9, 5'd0, 2'b01, 2'b01);
        step();
        checks++; if ({stall, bubble} !== 2'b11) begin errors++; $display("FAIL lu_stall got %b want 11", {stall, bubble}); end
        checks++; if (src_sel !== 4'b0001) begin errors++; $display("FAIL lu_sel got %b want 0001", src_sel); end
        set_in(5'd9, 5'd1, 2'b11, 1'b0, 5'd0, 5'd9, 2'b10, 2'b00);
        step();
        checks++; if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL lu_release got %b want 00", {stall, bubble}); end
        checks++; if (src_sel !== 4'b0010) begin errors++; $display("FAIL lu_resolve got %b want 0010", src_sel); end
`ifdef FWD_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic exp_stall;
        set_in(5'd9, 5'd1, 2'b11, 1'b0, 5'd9, 5'd0, 2'b01, 2'b01);
        for (int i = 0; i < 4; i++) begin
            exp_stall = (i % 2 == 0);
            step();
            checks++;
            if (stall !== exp_stall) begin
                errors++; $display("FAIL b2b_stall cycle %0d got %b want %b", i, stall, exp_stall);
            end
        end
        set_in(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00);
        step();
    endtask

    task automatic test_flush();
        set_in(5'd9, 5'd9, 2'b11, 1'b0, 5'd9, 5'd9, 2'b11, 2'b01);
        flush = 1'b1;
        step();
        checks++; if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL flush_hazard got %b want 00", {stall, bubble}); end
        checks++; if ({src_sel, store_sel} !== 6'd0) begin errors++; $display("FAIL flush_sel got %b want 000000", {src_sel, store_sel}); end
        flush = 1'b0;
        step();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_prestall got %b want 1", stall); end
        flush = 1'b1;
        step();
        checks++; if ({stall, src_sel} !== 5'd0) begin errors++; $display("FAIL flush_in_stall got %b want 00000", {stall, src_sel}); end
        flush = 1'b0;
        step();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_back_to_run got %b want 1", stall); end
        set_in(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00);
        step();
    endtask

    task automatic test_reset_mid_stall();
        set_in(5'd9, 5'd9, 2'b11, 1'b0, 5'd9, 5'd9, 2'b11, 2'b01);
        step();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_prestall got %b want 1", stall); end
        rst_n = 1'b0;
        step();
        checks++; if ({src_sel, store_sel, stall, bubble} !== 8'd0) begin
            errors++; $display("FAIL rst_mid_stall got %b want 00000000", {src_sel, store_sel, stall, bubble});
        end
`ifdef FWD_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", stall_cnt); end
`endif
        set_in(5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00);
        rst_n = 1'b1;
        step();
        checks++; if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL rst_no_resume got %b want 00", {stall, bubble}); end
    endtask

    initial begin
        test_reset();
        test_forward_basic();
        test_youngest_and_imm();
        test_no_forward();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
